// File: rtl/ni_route_lookup_arbiter_pkg.sv
// Shared defaults, FSM encoding and small helpers for the NI route lookup arbiter.
// Every file of the arbiter imports this package.
package ni_route_lookup_arbiter_pkg;

    localparam int DEF_N_REQ         = 2;
    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_PATH_WIDTH    = 7;
    localparam int DEF_TARGET_WIDTH  = 4;
    localparam int DEF_ERR_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ni_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces a one-hot grant plus its encoded index; the pointer register lives in the parent.
module ni_rr_arbiter
    import ni_route_lookup_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr < N_REQ and i < N_REQ, so a single subtraction wraps the sum.
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_route_lookup_arbiter.sv
// Shares one combinational NI routing table between N_REQ requesters: round-robin accept,
// one-cycle registered lookup, valid/ready response to the winner, plus decode-error status.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
// req_ready is a one-hot offer that only exists in IDLE; rsp_valid stays asserted with rsp_*
// stable until the granted requester's rsp_ready bit is 1 (other bits are ignored).
module ni_route_lookup_arbiter
    import ni_route_lookup_arbiter_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int PATH_WIDTH    = DEF_PATH_WIDTH,
    parameter int TARGET_WIDTH  = DEF_TARGET_WIDTH,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]       lut_address,
    input  logic [PATH_WIDTH-1:0]       lut_path,
    input  logic [TARGET_WIDTH-1:0]     lut_target,
    input  logic                        lut_failed,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [PATH_WIDTH-1:0]       rsp_path,
    output logic [TARGET_WIDTH-1:0]     rsp_target,
    output logic                        rsp_fail,
    output logic [ERR_CNT_WIDTH-1:0]    err_count,
    output logic [ADDR_WIDTH-1:0]       err_addr,
    output logic                        err_valid,
    input  logic                        err_clear,
    output logic [1:0]                  fsm_state
);

    localparam int IDX_W = idx_width(N_REQ);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] grant_q;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    logic                  accept;
    logic                  rsp_done;
    logic                  lookup_fail;
    logic [N_REQ-1:0]      grant_onehot;
    logic [ADDR_WIDTH-1:0] sel_addr;

    ni_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    always_comb begin
        req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
        accept    = (state_q == ST_IDLE) && arb_any;

        grant_onehot          = '0;
        grant_onehot[grant_q] = 1'b1;
        rsp_valid = (state_q == ST_RESP) ? grant_onehot : '0;
        rsp_done  = (state_q == ST_RESP) && rsp_ready[grant_q];

        lookup_fail = (state_q == ST_LOOKUP) && lut_failed;

        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end

        ptr_next = (arb_idx == IDX_W'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = ST_RESP;
            ST_RESP:   if (rsp_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign fsm_state = state_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            lut_address <= '0;
            rsp_path    <= '0;
            rsp_target  <= '0;
            rsp_fail    <= 1'b0;
            err_count   <= '0;
            err_addr    <= '0;
            err_valid   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                grant_q     <= arb_idx;
                ptr_q       <= ptr_next;
                lut_address <= sel_addr;
            end

            // Table outputs go straight through; a failed decode already reports zero path/target.
            if (state_q == ST_LOOKUP) begin
                rsp_path   <= lut_path;
                rsp_target <= lut_target;
                rsp_fail   <= lut_failed;
            end

            // A clear wins over a failure in the same cycle, which is then dropped entirely.
            if (err_clear) begin
                err_count <= '0;
                err_addr  <= '0;
                err_valid <= 1'b0;
            end else if (lookup_fail) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!err_valid) begin
                    err_addr  <= lut_address;
                    err_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ni_route_lookup_arbiter.sv
// Self-checking bench for ni_route_lookup_arbiter with N_REQ=2: directed vector table,
// hand-written corner sequences and randomized transactions against a reference model.
module tb_ni_route_lookup_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;

    logic          clock;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic [AW-1:0] lut_address;
    logic [6:0]    lut_path;
    logic [3:0]    lut_target;
    logic          lut_failed;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [6:0]    rsp_path;
    logic [3:0]    rsp_target;
    logic          rsp_fail;
    logic [7:0]    err_count;
    logic [AW-1:0] err_addr;
    logic          err_valid;
    logic          err_clear;
    logic [1:0]    fsm_state;

    ni_route_lookup_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .lut_address (lut_address),
        .lut_path    (lut_path),
        .lut_target  (lut_target),
        .lut_failed  (lut_failed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_path    (rsp_path),
        .rsp_target  (rsp_target),
        .rsp_fail    (rsp_fail),
        .err_count   (err_count),
        .err_addr    (err_addr),
        .err_valid   (err_valid),
        .err_clear   (err_clear),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- routing table (environment) ----------------
    // Returns {failed, target[3:0], path[6:0]}. Region 0x1xxxxxxx decodes, all else fails.
    function automatic logic [11:0] lut_fn(input logic [31:0] a);
        if (a[31:28] != 4'h1) return {1'b1, 4'h0, 7'h00};
        case (a[27:20])
            8'h00:   return {1'b0, 4'h1, 7'h00};
            8'h04:   return {1'b0, 4'h5, 7'h01};
            8'ha0:   return {1'b0, 4'hc, 7'h07};
            default: return {1'b0, a[23:20], a[26:20]};
        endcase
    endfunction

    always_comb {lut_failed, lut_target, lut_path} = lut_fn(lut_address);

    // ---------------- reference model state ----------------
    int          m_ptr;
    int          m_cnt;
    logic [31:0] m_eaddr;
    logic        m_evalid;

    function automatic int rr_pick(input logic [1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'h1040_0000;
            1:       return 32'h1000_0000;
            2:       return 32'h1a00_0000;
            3:       return {4'h1, 28'($urandom)};
            4:       return {4'h2, 28'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    int tests;
    int fails;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_path", rsp_path, 0);
        check("rst_rsp_target", rsp_target, 0);
        check("rst_rsp_fail", rsp_fail, 0);
        check("rst_lut_address", lut_address, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_fsm_state", fsm_state, 0);
    endtask

    // ---------------- driver ----------------
    // Starts and ends just after a falling edge with the DUT idle.
    task automatic do_txn(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] a1,
                          input int hold, input logic [1:0] next_valid, input bit clr_lookup,
                          input int g, input logic [6:0] ep, input logic [3:0] et, input logic ef);
        logic [1:0]  oh;
        logic [31:0] wa;
        oh = 2'b01 << g;
        wa = (g == 0) ? a0 : a1;
        req_valid = valid;
        req_addr  = {a1, a0};
        rsp_ready = 2'b00;
        #1;
        check("req_ready_idle", req_ready, oh);
        @(posedge clock);
        @(negedge clock);
        req_valid = next_valid;
        req_addr  = {$urandom, $urandom};
        if (clr_lookup) err_clear = 1'b1;
        check("lookup_state", fsm_state, 1);
        check("lookup_rsp_valid", rsp_valid, 0);
        check("lookup_req_ready", req_ready, 0);
        check("lut_address", lut_address, wa);
        m_ptr = (g + 1) % N;
        if (clr_lookup) begin
            m_cnt = 0; m_eaddr = '0; m_evalid = 1'b0;
        end else if (ef) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_evalid) begin
                m_eaddr = wa; m_evalid = 1'b1;
            end
        end
        @(negedge clock);
        err_clear = 1'b0;
        check("rsp_valid", rsp_valid, oh);
        check("rsp_path", rsp_path, ep);
        check("rsp_target", rsp_target, et);
        check("rsp_fail", rsp_fail, ef);
        check("resp_state", fsm_state, 2);
        check("err_count", err_count, m_cnt);
        check("err_addr", err_addr, m_eaddr);
        check("err_valid", err_valid, m_evalid);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~oh;
            @(negedge clock);
            check("hold_rsp_valid", rsp_valid, oh);
            check("hold_rsp_path", rsp_path, ep);
            check("hold_rsp_target", rsp_target, et);
            check("hold_rsp_fail", rsp_fail, ef);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = oh | 2'($urandom);
        @(negedge clock);
        rsp_ready = 2'b00;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_state", fsm_state, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] a1;
        int          hold;
        int          grant;
        logic [6:0]  path;
        logic [3:0]  target;
        logic        fail;
    } vec_t;

    vec_t vecs[8];

    logic [1:0] exp_q[$];

    initial begin
        logic [11:0] r;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  v;
        logic [1:0]  nv;
        int          g;

        // Pointer starts at 0; each entry moves it to grant+1.
        vecs[0] = '{2'b01, 32'h1040_0000, 32'h0000_0000, 5, 0, 7'h01, 4'h5, 1'b0};
        vecs[1] = '{2'b11, 32'h1000_0000, 32'h1a00_0000, 0, 1, 7'h07, 4'hc, 1'b0};
        vecs[2] = '{2'b11, 32'h1000_0000, 32'h1a00_0000, 0, 0, 7'h00, 4'h1, 1'b0};
        vecs[3] = '{2'b11, 32'h1000_0000, 32'h1a00_0000, 1, 1, 7'h07, 4'hc, 1'b0};
        vecs[4] = '{2'b01, 32'h2000_0000, 32'h0000_0000, 0, 0, 7'h00, 4'h0, 1'b1};
        vecs[5] = '{2'b01, 32'h3000_0000, 32'h0000_0000, 2, 0, 7'h00, 4'h0, 1'b1};
        vecs[6] = '{2'b10, 32'h0000_0000, 32'h1040_0000, 0, 1, 7'h01, 4'h5, 1'b0};
        vecs[7] = '{2'b11, 32'h3000_0000, 32'h1a00_0000, 0, 0, 7'h00, 4'h0, 1'b1};

        tests = 0; fails = 0;
        m_ptr = 0; m_cnt = 0; m_eaddr = '0; m_evalid = 1'b0;
        reset_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = '0; err_clear = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_state();
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].hold, 2'b00, 1'b0,
                   vecs[i].grant, vecs[i].path, vecs[i].target, vecs[i].fail);
        end
        check("err_first_addr", err_addr, 32'h2000_0000);
        check("err_count_after_table", err_count, 3);

        // Continuous contention: accepts every third cycle, grants alternate.
        req_valid = 2'b11;
        req_addr  = {32'h1a00_0000, 32'h1000_0000};
        rsp_ready = 2'b11;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (cyc % 3 == 0) begin
                g = rr_pick(2'b11, m_ptr);
                m_ptr = (g + 1) % N;
                exp_q.push_back(2'(g));
                check("cont_req_ready", req_ready, 2'b01 << g);
            end else begin
                check("cont_req_ready_busy", req_ready, 0);
            end
            if (cyc % 3 == 2) begin
                g = int'(exp_q.pop_front());
                r = lut_fn(g == 0 ? 32'h1000_0000 : 32'h1a00_0000);
                check("cont_rsp_valid", rsp_valid, 2'b01 << g);
                check("cont_rsp_path", rsp_path, r[6:0]);
                check("cont_rsp_target", rsp_target, r[10:7]);
            end
            @(negedge clock);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // Requester 1 alone, requester 0 joins during its response; addr1 changes after accept.
        g = rr_pick(2'b10, m_ptr);
        do_txn(2'b10, 32'h0, 32'h1040_0000, 2, 2'b11, 1'b0, g, 7'h01, 4'h5, 1'b0);
        g = rr_pick(2'b11, m_ptr);
        check("reassign_grant_req0", g, 0);
        r = lut_fn(g == 0 ? 32'h1000_0000 : 32'h1a00_0000);
        do_txn(2'b11, 32'h1000_0000, 32'h1a00_0000, 0, 2'b00, 1'b0, g, r[6:0], r[10:7], r[11]);

        // Saturation, then a clear coinciding with a failing lookup.
        for (int i = 0; i < 260; i++) begin
            g = rr_pick(2'b01, m_ptr);
            do_txn(2'b01, 32'h2000_0000 + i, 32'h0, 0, 2'b00, 1'b0, g, 7'h00, 4'h0, 1'b1);
        end
        check("err_count_saturated", err_count, 8'hff);
        g = rr_pick(2'b01, m_ptr);
        do_txn(2'b01, 32'h3000_0000, 32'h0, 0, 2'b00, 1'b1, g, 7'h00, 4'h0, 1'b1);
        check("err_count_cleared", err_count, 0);
        check("err_valid_cleared", err_valid, 0);

        // Reset while a response is pending.
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h1040_0000};
        rsp_ready = 2'b00;
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
        @(negedge clock);
        check("pre_reset_rsp_valid", rsp_valid, 2'b01);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_reset_state();
        m_ptr = 0; m_cnt = 0; m_eaddr = '0; m_evalid = 1'b0;
        g = rr_pick(2'b11, m_ptr);
        r = lut_fn(g == 0 ? 32'h1040_0000 : 32'h1a00_0000);
        do_txn(2'b11, 32'h1040_0000, 32'h1a00_0000, 1, 2'b00, 1'b0, g, r[6:0], r[10:7], r[11]);

        // Randomized transactions against the model.
        nv = 2'b00;
        for (int i = 0; i < 150; i++) begin
            v  = (nv != 2'b00 && $urandom_range(0, 1) == 1) ? nv : 2'($urandom_range(1, 3));
            a0 = rand_addr();
            a1 = rand_addr();
            g  = rr_pick(v, m_ptr);
            r  = lut_fn(g == 0 ? a0 : a1);
            nv = 2'($urandom_range(0, 3));
            do_txn(v, a0, a1, $urandom_range(0, 3), nv, ($urandom_range(0, 9) == 0),
                   g, r[6:0], r[10:7], r[11]);
        end
        req_valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
